// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Receives a framed byte stream over a valid/ready handshake,
//                assembles big-endian instruction words and drives the
//                processor's instruction-RAM initialisation port. The frame is
//                LEN_HI, LEN_LO (word count N), N*DATA_WIDTH/8 payload bytes,
//                then an XOR checksum byte covering header and payload.
//                init_active stays high for the whole load and is released
//                only after the checksum verifies.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                rx_data/rx_valid    - incoming byte and its valid flag
//                rx_ready            - loader can accept a byte
//                init_wadrs/wdata    - RAM init write address / data
//                init_active         - to initialize_instructions
//                load_done           - frame loaded and verified
//                load_error/err_code - frame aborted; 01 length, 10 checksum,
//                                      11 timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDRESS_WIDTH  = 12,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   output logic                     rx_ready,
   output logic [ADDRESS_WIDTH-1:0] init_wadrs,
   output logic [DATA_WIDTH-1:0]    init_wdata,
   output logic                     init_active,
   output logic                     load_done,
   output logic                     load_error,
   output logic [1:0]               err_code
);

   localparam int c_BYTES = DATA_WIDTH / 8;
   localparam int c_BCW   = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
   localparam int c_ASMW  = (DATA_WIDTH > 8) ? DATA_WIDTH - 8 : 1;
   localparam int c_TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [63:0] c_MAX_WORDS = 64'(1) << ADDRESS_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LEN_LO  = 3'd1,
      S_PAYLOAD = 3'd2,
      S_CHECK   = 3'd3,
      S_DONE    = 3'd4,
      S_ERROR   = 3'd5
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [1:0]               w_err_nxt;

   logic [7:0]               r_len_hi;
   logic [7:0]               r_chk;
   logic [15:0]              r_words_left;
   logic [c_BCW-1:0]         r_byte_cnt;
   logic [ADDRESS_WIDTH-1:0] r_word_idx;
   logic [c_ASMW-1:0]        r_asm;
   logic [c_TW-1:0]          r_tmo;

   logic [ADDRESS_WIDTH-1:0] r_init_wadrs;
   logic [DATA_WIDTH-1:0]    r_init_wdata;
   logic                     r_init_active;
   logic [1:0]               r_err_code;

   logic                     w_accept;
   logic                     w_in_frame;
   logic [15:0]              w_len;
   logic                     w_len_bad;
   logic                     w_last_byte;
   logic                     w_last_word;
   logic                     w_tmo_hit;
   logic [DATA_WIDTH-1:0]    w_word;

   assign rx_ready    = (r_state == S_IDLE) || (r_state == S_LEN_LO) ||
                        (r_state == S_PAYLOAD) || (r_state == S_CHECK);
   assign w_accept    = rx_valid && rx_ready;
   assign w_in_frame  = (r_state == S_LEN_LO) || (r_state == S_PAYLOAD) ||
                        (r_state == S_CHECK);
   assign w_len       = {r_len_hi, rx_data};
   assign w_len_bad   = (w_len == 16'd0) || (64'(w_len) > c_MAX_WORDS);
   assign w_last_byte = (r_byte_cnt == c_BCW'(c_BYTES - 1));
   assign w_last_word = (r_words_left == 16'd1);
   // Counter value TIMEOUT_CYCLES-1 plus one more idle cycle reaches the limit.
   assign w_tmo_hit   = (TIMEOUT_CYCLES != 0) && w_in_frame && !w_accept &&
                        (r_tmo == c_TW'(TIMEOUT_CYCLES - 1));

   // Incoming byte lands in the LSBs; earlier bytes already sit above it.
   generate
      if (c_BYTES > 1) begin : g_multi_byte
         assign w_word = {r_asm, rx_data};
      end else begin : g_single_byte
         assign w_word = rx_data;
      end
   endgenerate

   assign init_wadrs  = r_init_wadrs;
   assign init_wdata  = r_init_wdata;
   assign init_active = r_init_active;
   assign err_code    = r_err_code;
   assign load_done   = (r_state == S_DONE);
   assign load_error  = (r_state == S_ERROR);

   always_comb begin
      w_state_nxt = r_state;
      w_err_nxt   = r_err_code;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (w_accept) begin
               if (w_len_bad) begin
                  w_state_nxt = S_ERROR;
                  w_err_nxt   = 2'b01;
               end else begin
                  w_state_nxt = S_PAYLOAD;
               end
            end else if (w_tmo_hit) begin
               w_state_nxt = S_ERROR;
               w_err_nxt   = 2'b11;
            end
         end
         S_PAYLOAD: begin
            if (w_accept) begin
               if (w_last_byte && w_last_word) w_state_nxt = S_CHECK;
            end else if (w_tmo_hit) begin
               w_state_nxt = S_ERROR;
               w_err_nxt   = 2'b11;
            end
         end
         S_CHECK: begin
            if (w_accept) begin
               if (rx_data == r_chk) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_ERROR;
                  w_err_nxt   = 2'b10;
               end
            end else if (w_tmo_hit) begin
               w_state_nxt = S_ERROR;
               w_err_nxt   = 2'b11;
            end
         end
         default: begin
            w_state_nxt = r_state;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_len_hi      <= '0;
         r_chk         <= '0;
         r_words_left  <= '0;
         r_byte_cnt    <= '0;
         r_word_idx    <= '0;
         r_asm         <= '0;
         r_tmo         <= '0;
         r_init_wadrs  <= '0;
         r_init_wdata  <= '0;
         r_init_active <= 1'b0;
         r_err_code    <= 2'b00;
      end else begin
         r_state    <= w_state_nxt;
         r_err_code <= w_err_nxt;

         if (w_in_frame && !w_accept) r_tmo <= r_tmo + 1'b1;
         else                         r_tmo <= '0;

         if (w_accept) begin
            case (r_state)
               S_IDLE: begin
                  r_len_hi <= rx_data;
                  r_chk    <= rx_data;
               end
               S_LEN_LO: begin
                  r_chk        <= r_chk ^ rx_data;
                  r_words_left <= w_len;
                  r_byte_cnt   <= '0;
                  r_word_idx   <= '0;
                  if (!w_len_bad) r_init_active <= 1'b1;
               end
               S_PAYLOAD: begin
                  r_chk <= r_chk ^ rx_data;
                  r_asm <= w_word[c_ASMW-1:0];
                  if (w_last_byte) begin
                     r_byte_cnt   <= '0;
                     r_init_wdata <= w_word;
                     r_init_wadrs <= r_word_idx;
                     // Wraps harmlessly after a full 2^ADDRESS_WIDTH load.
                     r_word_idx   <= r_word_idx + 1'b1;
                     r_words_left <= r_words_left - 16'd1;
                  end else begin
                     r_byte_cnt <= r_byte_cnt + 1'b1;
                  end
               end
               S_CHECK: begin
                  // A mismatch leaves init_active high so the processor stays held.
                  if (rx_data == r_chk) r_init_active <= 1'b0;
               end
               default: begin
                  r_chk <= r_chk;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_loader
//  Description : Self-checking bench for program_loader (32-bit words,
//                12-bit addresses, 16-cycle timeout). Expected outputs come
//                from a frame-level model evaluated on the number of bytes
//                accepted so far.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

   localparam int DW = 32;
   localparam int AW = 12;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [AW-1:0] init_wadrs;
   logic [DW-1:0] init_wdata;
   logic          init_active;
   logic          load_done;
   logic          load_error;
   logic [1:0]    err_code;

   program_loader #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .init_wadrs (init_wadrs),
      .init_wdata (init_wdata),
      .init_active(init_active),
      .load_done  (load_done),
      .load_error (load_error),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] frm[$];

   typedef struct {
      logic [7:0] hi;
      logic [7:0] lo;
      logic       ready;
      logic       active;
      logic [1:0] code;
   } hdr_vec_t;
   hdr_vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Expected outputs after p bytes of frm have been accepted.
   task automatic model_check(input int p);
      int            n;
      int            words;
      int            b;
      logic [7:0]    x;
      logic          e_ready, e_active, e_done, e_err;
      logic [1:0]    e_code;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_data;
      e_ready = 1; e_active = 0; e_done = 0; e_err = 0; e_code = 0;
      e_addr = 0; e_data = 0;
      if (p >= 2) begin
         n = {frm[0], frm[1]};
         if (n == 0 || n > (1 << AW)) begin
            e_ready = 0; e_err = 1; e_code = 2'b01;
         end else begin
            e_active = 1;
            words = (p - 2) / 4;
            if (words > n) words = n;
            if (words > 0) begin
               b = 2 + 4 * (words - 1);
               e_addr = AW'(words - 1);
               e_data = {frm[b], frm[b+1], frm[b+2], frm[b+3]};
            end
            if (p == 4 * n + 3) begin
               x = 0;
               for (int i = 0; i < 4 * n + 2; i++) x ^= frm[i];
               e_ready = 0;
               if (x == frm[4*n+2]) begin
                  e_done = 1; e_active = 0;
               end else begin
                  e_err = 1; e_code = 2'b10;
               end
            end
         end
      end
      chk("rx_ready",    64'(rx_ready),    64'(e_ready));
      chk("init_active", 64'(init_active), 64'(e_active));
      chk("load_done",   64'(load_done),   64'(e_done));
      chk("load_error",  64'(load_error),  64'(e_err));
      chk("err_code",    64'(err_code),    64'(e_code));
      chk("init_wadrs",  64'(init_wadrs),  64'(e_addr));
      chk("init_wdata",  64'(init_wdata),  64'(e_data));
   endtask

   // Called at a negedge; returns at a negedge.
   task automatic send_frame(input int nsend, input int gap_max, output int p);
      p = 0;
      for (int i = 0; i < nsend; i++) begin
         if (!rx_ready) break;
         if (gap_max > 0) begin
            int g;
            g = $urandom_range(0, gap_max);
            repeat (g) @(negedge clk);
         end
         rx_valid = 1'b1;
         rx_data  = frm[i];
         @(posedge clk);
         #1;
         rx_valid = 1'b0;
         p = i + 1;
         model_check(p);
         @(negedge clk);
      end
   endtask

   task automatic do_reset(input logic valid_during);
      @(negedge clk);
      reset    = 1'b1;
      rx_valid = valid_during;
      rx_data  = 8'hFF;
      @(negedge clk);
      reset    = 1'b0;
      rx_valid = 1'b0;
      model_check(0);
   endtask

   task automatic idle_check(input int p);
      repeat (3) @(negedge clk);
      model_check(p);
   endtask

   task automatic load_first_frame(input logic [7:0] chk_byte);
      frm = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
              8'h00, 8'h00, 8'h00, 8'h2A, chk_byte};
   endtask

   initial begin
      int p;
      int n;
      logic [7:0] x;

      vecs[0] = '{8'h00, 8'h00, 1'b0, 1'b0, 2'b01};
      vecs[1] = '{8'h00, 8'h01, 1'b1, 1'b1, 2'b00};
      vecs[2] = '{8'h10, 8'h00, 1'b1, 1'b1, 2'b00};
      vecs[3] = '{8'h10, 8'h01, 1'b0, 1'b0, 2'b01};
      vecs[4] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 2'b01};
      vecs[5] = '{8'h08, 8'h00, 1'b1, 1'b1, 2'b00};

      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (2) @(negedge clk);
      do_reset(1'b0);

      // Two-word reference frame, back-to-back.
      load_first_frame(8'h0A);
      send_frame(frm.size(), 0, p);
      chk("frame1_bytes", 64'(p), 64'd11);
      idle_check(p);
      chk("frame1_last_data", 64'(init_wdata), 64'h0000002A);
      chk("frame1_last_addr", 64'(init_wadrs), 64'd1);

      // Same frame with random gaps.
      do_reset(1'b0);
      load_first_frame(8'h0A);
      send_frame(frm.size(), 3, p);
      chk("frame2_bytes", 64'(p), 64'd11);
      idle_check(p);

      // Bad checksum.
      do_reset(1'b0);
      load_first_frame(8'h0B);
      send_frame(frm.size(), 2, p);
      idle_check(p);
      chk("badchk_err", 64'(err_code), 64'd2);
      chk("badchk_active", 64'(init_active), 64'd1);

      // Header length boundary table.
      foreach (vecs[v]) begin
         do_reset(1'b0);
         frm = '{vecs[v].hi, vecs[v].lo};
         send_frame(2, 0, p);
         chk("hdr_ready",  64'(rx_ready),    64'(vecs[v].ready));
         chk("hdr_active", 64'(init_active), 64'(vecs[v].active));
         chk("hdr_code",   64'(err_code),    64'(vecs[v].code));
      end

      // Timeout after three payload bytes.
      do_reset(1'b0);
      load_first_frame(8'h0A);
      send_frame(5, 0, p);
      repeat (15) @(negedge clk);
      chk("tmo_pre_ready", 64'(rx_ready), 64'd1);
      chk("tmo_pre_error", 64'(load_error), 64'd0);
      @(negedge clk);
      chk("tmo_error",  64'(load_error),  64'd1);
      chk("tmo_code",   64'(err_code),    64'd3);
      chk("tmo_active", 64'(init_active), 64'd1);
      chk("tmo_ready",  64'(rx_ready),    64'd0);

      // Reset mid-payload (with a byte offered during reset), then a fresh frame.
      do_reset(1'b0);
      load_first_frame(8'h0A);
      send_frame(4, 0, p);
      do_reset(1'b1);
      frm = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
      send_frame(frm.size(), 1, p);
      chk("rst_frame_bytes", 64'(p), 64'd7);
      chk("rst_frame_data", 64'(init_wdata), 64'h12345678);
      chk("rst_frame_addr", 64'(init_wadrs), 64'd0);
      chk("rst_frame_done", 64'(load_done), 64'd1);

      // Random frames, some with corrupted checksum.
      for (int t = 0; t < 20; t++) begin
         do_reset(1'b0);
         n = $urandom_range(1, 8);
         frm.delete();
         frm.push_back(8'(n >> 8));
         frm.push_back(8'(n));
         for (int i = 0; i < 4 * n; i++) frm.push_back(8'($urandom_range(0, 255)));
         x = 0;
         foreach (frm[i]) x ^= frm[i];
         if ($urandom_range(0, 1) == 1) x ^= 8'($urandom_range(1, 255));
         frm.push_back(x);
         send_frame(frm.size(), 3, p);
         chk("rand_bytes", 64'(p), 64'(frm.size()));
         idle_check(p);
      end

      // Maximum-size load: final address all-ones.
      do_reset(1'b0);
      n = 1 << AW;
      frm.delete();
      frm.push_back(8'(n >> 8));
      frm.push_back(8'(n));
      for (int i = 0; i < 4 * n; i++) frm.push_back(8'($urandom_range(0, 255)));
      x = 0;
      foreach (frm[i]) x ^= frm[i];
      frm.push_back(x);
      send_frame(frm.size(), 0, p);
      chk("max_bytes", 64'(p), 64'(frm.size()));
      chk("max_addr", 64'(init_wadrs), 64'hFFF);
      chk("max_done", 64'(load_done), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream feeder for the processor FSM's instruction-initialisation port.
- Accepts a framed byte stream over a valid/ready handshake, from a UART receiver or the testbench host.
- Assembles big-endian DATA_WIDTH words and drives the RAM init address, init data and initialize_instructions.
- Holds initialize_instructions high for the whole load. Releases it only after the frame checksum verifies, which lets the processor leave WRITE and start fetching.

Parameters:
- DATA_WIDTH, 32, instruction word width; must be a multiple of 8.
- ADDRESS_WIDTH, 12, RAM address width; maximum load is 2^ADDRESS_WIDTH words.
- TIMEOUT_CYCLES, 1000000, idle cycles allowed mid-frame before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte.
- init_wadrs  out  ADDRESS_WIDTH  RAM init write address (to ram_init_wadrs).
- init_wdata  out  DATA_WIDTH  RAM init write data (to ram_write_instruction).
- init_active  out  1  to initialize_instructions.
- load_done  out  1  frame loaded and verified.
- load_error  out  1  frame aborted.
- err_code  out  2  00 none, 01 bad length, 10 checksum mismatch, 11 timeout.

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-high. It forces state IDLE and zeroes all outputs except rx_ready, which is 1 in IDLE. It also clears word/byte counters, the checksum accumulator and the timeout counter. Reset overrides a byte accepted in the same cycle. Reset mid-load abandons the frame; no further words are emitted.
- Byte acceptance: a byte is accepted on a posedge where rx_valid && rx_ready.
- Frame format: LEN_HI, LEN_LO (16-bit word count N), then N*DATA_WIDTH/8 payload bytes (first byte goes to MSBs), then CHK.
- Checksum: CHK must equal the XOR of all header and payload bytes.
- States and transitions:
  - IDLE: on accept, latch LEN_HI and go to LEN_LO.
  - LEN_LO: on accept, form N. If N==0 or N>2^ADDRESS_WIDTH, go to ERROR with code 01. Otherwise go to PAYLOAD and set init_active=1.
  - PAYLOAD: shift bytes into a private assembly register. When a word's last byte is accepted, at that same edge: init_wdata = the assembled word, init_wadrs = word index k (0-based), k++.
  - PAYLOAD exit: after word N-1 completes, go to CHECK.
  - CHECK: on accept, compare CHK. Match: go to DONE. Mismatch: go to ERROR with code 10.
  - DONE: init_active=0, load_done=1, rx_ready=0. Terminal until reset.
  - ERROR: load_error=1, err_code held, rx_ready=0. init_active keeps its value from entry: 1 if entered from PAYLOAD/CHECK or timeout, 0 if from the length check. A failed load therefore never lets the processor run. Terminal until reset.
- rx_ready is 1 in IDLE, LEN_LO, PAYLOAD and CHECK.
- init_wadrs/init_wdata change only at word-completion edges and are otherwise stable. The RAM rewrites the same word every cycle while init_active=1, which is harmless.
- Before word 0 completes they hold 0/0, so address 0 is written with 0 and later overwritten.
- The last word is presented for at least one cycle with init_active=1, because the CHK byte occupies at least one more cycle.
- Timeout: in LEN_LO, PAYLOAD and CHECK, a counter increments on every cycle with no accept and clears on accept. If it reaches TIMEOUT_CYCLES (nonzero), go to ERROR with code 11. IDLE never times out.
- N = 2^ADDRESS_WIDTH is legal; the final init_wadrs is all-ones and k wraps without effect.
- Gaps and back-to-back bytes: arbitrary gaps in rx_valid change nothing but timing. Back-to-back bytes sustain 1 byte/cycle.

Test Plan:
- 2-word load, 32/12: bytes 00 02 DE AD BE EF 00 00 00 2A 0A. Required: init_wdata=DEADBEEF at addr 0, then 0000002A at addr 1; init_active high from the LEN_LO accept until the CHK accept; load_done=1; err_code=00.
- Same frame with rx_valid toggled randomly: identical address/data sequence and final state.
- Same frame with CHK=0B: load_error=1, err_code=10, init_active stays 1, rx_ready=0.
- Header 10 01 (4097 > 4096): ERROR, err_code=01, init_active never asserted.
- TIMEOUT_CYCLES=16, stop after 3 payload bytes: 16 idle cycles later, err_code=11 and init_active=1.
- Reset asserted mid-payload, then a fresh 1-word frame 00 01 12 34 56 78 CHK=0x09: outputs return to 0, then 12345678 is written at addr 0 and load_done=1.
